port_uart_tx: RTL and testbench

PORT_UART_TX -- requirements
Module: port_uart_tx

---
 rtl/port_uart_tx.sv | 179 +++++++++++++++++
 tb/tb_port_uart_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/port_uart_tx.sv
// Byte-port UART transmitter with a 4-deep FIFO.
// Toggle handshake push, sticky overflow, 8N1 serial output.
module port_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_data,
    input  logic [7:0] port_cmd,
    output logic [7:0] status,
    output logic       tx
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [9:0] LAST = 10'(CLKS_PER_BIT - 1);

    state_t     state;
    state_t     state_n;
    logic [9:0] cnt;
    logic [9:0] cnt_n;
    logic [2:0] bit_idx;
    logic [2:0] bit_n;
    logic [7:0] shift;
    logic [7:0] shift_n;
    logic       tx_q;
    logic       tx_n;

    logic [7:0] mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic       overflow;
    logic       tack;

    logic       enable;
    logic       push;
    logic       pop;
    logic       write;
    logic       ovf_set;
    logic       bit_end;
    logic       avail;

    assign enable  = port_cmd[7];
    assign push    = port_cmd[0] != tack;
    assign bit_end = cnt == LAST;
    assign avail   = (count != 3'd0) && enable;
    assign write   = push && ((count != 3'd4) || pop);
    assign ovf_set = push && (count == 3'd4) && !pop;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, pop decision and next serial output
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 10'd1;
        bit_n   = bit_idx;
        shift_n = shift;
        tx_n    = tx_q;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = 10'd0;
                tx_n  = 1'b1;
                if (avail) begin
                    pop     = 1'b1;
                    state_n = START;
                    shift_n = mem[rd_ptr];
                    tx_n    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    cnt_n   = 10'd0;
                    bit_n   = 3'd0;
                    tx_n    = shift[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n   = 10'd0;
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                        tx_n  = shift[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_n = 10'd0;
                    if (avail) begin
                        pop     = 1'b1;
                        state_n = START;
                        shift_n = mem[rd_ptr];
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    // Bit timing, shift register and registered line output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= 10'd0;
            bit_idx <= 3'd0;
            shift   <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
            tx_q    <= tx_n;
        end
    end

    // FIFO storage, pointers, occupancy, overflow and toggle ack
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                mem[i] <= 8'd0;
            end
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count    <= 3'd0;
            overflow <= 1'b0;
            tack     <= 1'b0;
        end else begin
            tack <= port_cmd[0];
            if (write) begin
                mem[wr_ptr] <= port_data;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            if (write && !pop) begin
                count <= count + 3'd1;
            end else if (pop && !write) begin
                count <= count - 3'd1;
            end
            if (port_cmd[1]) begin
                overflow <= 1'b0;
            end else if (ovf_set) begin
                overflow <= 1'b1;
            end
        end
    end

    assign status = {tack, count, overflow,
                     count == 3'd0, count == 3'd4,
                     state != IDLE};
    assign tx     = tx_q;

endmodule

// File: tb/tb_port_uart_tx.sv
// Bench for port_uart_tx: queue-based byte model,
// expected line waveform built from frame arithmetic.
module tb_port_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] port_data;
    logic [7:0] port_cmd;
    logic [7:0] status;
    logic       tx;

    int            errors = 0;
    int            checks = 0;
    byte unsigned  q[$];
    logic          m_tack;
    logic          m_ovf;

    always #5 clk = ~clk;

    port_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .port_data (port_data),
        .port_cmd  (port_cmd),
        .status    (status),
        .tx        (tx)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_status(input logic busy);
        int sz;
        sz = q.size();
        return {m_tack, 3'(sz), m_ovf, sz == 0, sz == 4, busy};
    endfunction

    task automatic cyc();
        if (port_cmd[1]) m_ovf = 1'b0;
        @(negedge clk);
    endtask

    task automatic model_push(input byte unsigned d, input bit pop_same);
        port_data   = d;
        port_cmd[0] = ~port_cmd[0];
        m_tack      = port_cmd[0];
        if (q.size() < 4 || pop_same) q.push_back(d);
        else m_ovf = 1'b1;
    endtask

    task automatic push(input byte unsigned d);
        model_push(d, 1'b0);
        cyc();
    endtask

    // Called at the first negedge of a frame; ends at the first negedge after it.
    task automatic check_frame(input int pa, input int pb);
        byte unsigned b;
        logic         e;
        checks++;
        assert (q.size() != 0) else begin
            errors++;
            $error("FAIL frame_start: got empty queue expected a byte");
        end
        if (q.size() == 0) return;
        b = q.pop_front();
        chk("frame_status", status, exp_status(1'b1));
        for (int i = 0; i < 10 * CPB; i++) begin
            if (i < CPB) e = 1'b0;
            else if (i >= 9 * CPB) e = 1'b1;
            else e = b[(i - CPB) / CPB];
            chk("frame_line", {6'd0, status[0], tx}, {6'd0, 1'b1, e});
            if (i == pa) model_push(8'($urandom), 1'b0);
            if (i == pb)
                model_push(8'($urandom), q.size() != 0 && port_cmd[7]);
            cyc();
        end
    endtask

    initial begin
        byte unsigned b;
        logic         e;
        logic         seen_low;
        int           n;

        reset     = 1'b0;
        port_cmd  = 8'h00;
        port_data = 8'h00;
        m_tack    = 1'b0;
        m_ovf     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_status", status, 8'h04);
        chk("rst_tx", {7'd0, tx}, 8'h01);
        reset = 1'b1;
        cyc();
        chk("post_rst_status", status, exp_status(1'b0));

        // Single frame of 0xA5
        port_cmd  = 8'h80;
        port_data = 8'hA5;
        cyc();
        push(8'hA5);
        chk("t1_pushed", status, exp_status(1'b0));
        chk("t1_tx_idle", {7'd0, tx}, 8'h01);
        cyc();
        check_frame(-1, -1);
        chk("t1_done", status, 8'h84);
        chk("t1_done_model", status, exp_status(1'b0));

        // Held toggle: no further frames
        seen_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (tx !== 1'b1 || status[0] !== 1'b0) seen_low = 1'b1;
            cyc();
        end
        chk("held_toggle_quiet", {7'd0, seen_low}, 8'h00);
        chk("held_toggle_tack", status, exp_status(1'b0));

        // Five pushes while disabled: fill, overflow, drop fifth
        port_cmd[7] = 1'b0;
        cyc();
        for (int i = 1; i <= 5; i++) push(8'(i));
        chk("fill_status", status, exp_status(1'b0));
        chk("fill_full_ovf", {4'd0, status[3], 1'b0, status[1], 1'b0},
            8'h0A);
        port_cmd[7] = 1'b1;
        cyc();
        for (int k = 0; k < 4; k++) check_frame(-1, -1);
        chk("fill_drained", status, exp_status(1'b0));
        seen_low = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tx !== 1'b1) seen_low = 1'b1;
            cyc();
        end
        chk("fifth_lost", {7'd0, seen_low}, 8'h00);

        // Overflow clear pulse, clear-wins, full push at STOP end
        port_cmd[7] = 1'b0;
        port_cmd[1] = 1'b1;
        cyc();
        port_cmd[1] = 1'b0;
        chk("ovf_cleared", status, exp_status(1'b0));
        for (int i = 0; i < 4; i++) push(8'($urandom));
        port_cmd[1] = 1'b1;
        push(8'($urandom));
        port_cmd[1] = 1'b0;
        chk("clear_wins", status, exp_status(1'b0));
        chk("clear_wins_ovf", {7'd0, status[3]}, 8'h00);
        push(8'($urandom));
        chk("ovf_set_again", status, exp_status(1'b0));
        port_cmd[1] = 1'b1;
        cyc();
        port_cmd[1] = 1'b0;
        port_cmd[7] = 1'b1;
        cyc();
        check_frame(10, 10 * CPB - 1);
        chk("stop_push_ovf", {7'd0, status[3]}, 8'h00);
        n = 0;
        while (q.size() != 0 && n < 8) begin
            check_frame(-1, -1);
            n++;
        end
        chk("t3_drained", status, exp_status(1'b0));

        // Random burst
        port_cmd[7] = 1'b0;
        cyc();
        n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++) push(8'($urandom));
        chk("burst_status", status, exp_status(1'b0));
        port_cmd[7] = 1'b1;
        cyc();
        n = 0;
        while (q.size() != 0 && n < 8) begin
            check_frame(-1, -1);
            n++;
        end
        chk("burst_drained", status, exp_status(1'b0));

        // Reset in the middle of data bit 3 with two bytes queued
        port_cmd[7] = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) push(8'($urandom));
        port_cmd[7] = 1'b1;
        cyc();
        b = q.pop_front();
        for (int i = 0; i <= 4 * CPB; i++) begin
            if (i < CPB) e = 1'b0;
            else e = b[(i - CPB) / CPB];
            chk("pre_rst_line", {7'd0, tx}, {7'd0, e});
            cyc();
        end
        #2;
        reset    = 1'b0;
        port_cmd = 8'h80;
        #1;
        q.delete();
        m_tack = 1'b0;
        m_ovf  = 1'b0;
        chk("abort_tx", {7'd0, tx}, 8'h01);
        chk("abort_status", status, 8'h04);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen_low = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (tx !== 1'b1) seen_low = 1'b1;
            cyc();
        end
        chk("no_frame_after_rst", {7'd0, seen_low}, 8'h00);
        chk("after_rst_status", status, exp_status(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
